mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
// MEM stage of the 32-bit pipeline. It sits between the EXE2MEM register and the MEM/WB boundary.
// - Resolves branches (pc_src).
// - Runs loads/stores on a req/ack data-memory port and stalls upstream until the access completes.
// - Registers the writeback bundle (ALU result, load data, dest, enables) for the WB stage.
// PARAMETERS
// DATA_W   32  data/address width
// DEST_W   5   register-file index width
// TIMEOUT  16  max BUSY cycles waiting for dmem_ack before forced completion (>=2)
// PORTS
// clk           in   1       clock, all state on posedge
// rst           in   1       synchronous, active-high reset
// wb_en_in      in   1       WB enable from EXE2MEM
// mem_r_en_in   in   1       load request from EXE2MEM
// mem_w_en_in   in   1       store request from EXE2MEM
// zero_in       in   1       ALU zero flag from EXE2MEM
// branch_in     in   1       branch instruction flag from EXE2MEM
// alu_res_in    in   DATA_W  ALU result / memory address
// st_val_in     in   DATA_W  store data
// dest_in       in   DEST_W  destination register
// dmem_rdata    in   DATA_W  read data, valid when dmem_ack=1
// dmem_ack      in   1       memory completion, 1-cycle pulse
// dmem_req      out  1       access request (registered, high for whole BUSY)
// dmem_we       out  1       1=store, 0=load (registered)
// dmem_addr     out  DATA_W  word-aligned address (registered)
// dmem_wdata    out  DATA_W  store data (registered)
// stall         out  1       combinational; freezes PC/IF/ID/EXE2MEM
// pc_src        out  1       combinational branch_in & zero_in
// wb_en_out     out  1       registered WB enable
// mem_to_reg    out  1       registered; 1 = select mem_data_out in WB
// alu_res_out   out  DATA_W  registered ALU result
// mem_data_out  out  DATA_W  registered load data
// dest_out      out  DEST_W  registered destination
// align_err     out  1       registered 1-cycle pulse: misaligned access dropped
// mem_err       out  1       registered 1-cycle pulse: access timed out
// BEHAVIOUR
// - Reset: every registered output is 0, FSM=IDLE, timeout counter=0. dmem_ack is ignored while rst=1.
// - Access pending (acc) = mem_r_en_in | mem_w_en_in. If both are set, store wins (dmem_we=1, mem_to_reg=0).
// - IDLE:
//   - acc & alu_res_in[1:0]==0: latch addr, wdata and we; go to BUSY; stall=1.
//   - acc & misaligned: no access, stall=0. Next edge: align_err=1 and wb_en_out=0. Other WB fields capture normally.
//   - ~acc: stall=0, WB bundle captured at the next edge (latency 1).
// - BUSY:
//   - dmem_req=1; counter increments each cycle.
//   - stall = ~dmem_ack & (cnt != TIMEOUT-1).
//   - On dmem_ack: mem_data_out<=dmem_rdata (load) or 0 (store); capture the WB bundle; go to IDLE.
//   - On cnt==TIMEOUT-1 without ack: complete with mem_data_out=0, wb_en_out=0, mem_err=1; go to IDLE.
// - Minimum load latency is 2 cycles from the instruction arriving to WB outputs valid.
//   - Zero-wait ack arrives in the first BUSY cycle.
// - While stall=1, WB outputs take a bubble each edge: wb_en_out=0, mem_to_reg=0, errs=0. Other fields hold.
// - Inputs are held stable by upstream while stall=1. dmem_ack in IDLE is ignored.
// - Reset mid-BUSY: the next edge returns to IDLE with dmem_req=0. A late ack is ignored.
// - Counter clears on every IDLE entry. No wrap is possible, since BUSY exits at TIMEOUT-1.
// - pc_src is purely combinational and independent of the FSM. A branch never asserts acc.
// TESTING
// - ALU op wb_en_in=1,alu_res_in=0x10,dest_in=3 -> next edge wb_en_out=1,alu_res_out=0x10,dest_out=3,stall=0
// - Load addr 0x40, ack 3 cycles after req, rdata=0xDEADBEEF -> stall 4 cyc, mem_data_out=0xDEADBEEF,mem_to_reg=1
// - Store addr 0x44,st_val 0x1234, ack same cycle as req -> dmem_we=1,dmem_wdata=0x1234, stall 1 cyc, wb_en_out=0
// - Load addr 0x42 -> no dmem_req, stall=0, next edge align_err=1, wb_en_out=0
// - Load, ack never arrives (TIMEOUT=16) -> stall for 16 cycles, then mem_err=1, wb_en_out=0, FSM IDLE
// - rst during BUSY, ack the cycle after -> dmem_req=0 after reset edge, all outputs 0, ack ignored

Source files
------------

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge port between the MEM stage (master) and data memory (slave).
interface mem_access_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: branch resolution, stalling load/store over a req/ack port,
// and the registered writeback bundle handed to WB.
module mem_access_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEST_W  = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              zero_in,
    input  logic              branch_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] st_val_in,
    input  logic [DEST_W-1:0] dest_in,
    mem_access_if.master      dmem,
    output logic              stall,
    output logic              pc_src,
    output logic              wb_en_out,
    output logic              mem_to_reg,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [DEST_W-1:0] dest_out,
    output logic              align_err,
    output logic              mem_err
);
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d, we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic              wb_en_q, wb_en_d, mem_to_reg_q, mem_to_reg_d;
    logic [DATA_W-1:0] alu_res_q, alu_res_d, mem_data_q, mem_data_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic              align_err_q, align_err_d, mem_err_q, mem_err_d;
    logic              acc, aligned, last, stall_c;

    assign acc     = mem_r_en_in | mem_w_en_in;
    assign aligned = (alu_res_in[1:0] == 2'b00);
    assign last    = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and next-output logic; outputs bubble by default while stalled.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wb_en_d      = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_res_d    = alu_res_q;
        mem_data_d   = mem_data_q;
        dest_d       = dest_q;
        align_err_d  = 1'b0;
        mem_err_d    = 1'b0;
        stall_c      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (acc && aligned) begin
                    stall_c = 1'b1;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = mem_w_en_in;
                    addr_d  = alu_res_in;
                    wdata_d = st_val_in;
                end else begin
                    // Plain ALU op, or a misaligned access that is dropped.
                    wb_en_d      = wb_en_in & ~acc;
                    mem_to_reg_d = mem_r_en_in & ~mem_w_en_in;
                    alu_res_d    = alu_res_in;
                    dest_d       = dest_in;
                    mem_data_d   = '0;
                    align_err_d  = acc;
                end
            end
            BUSY: begin
                stall_c = ~dmem.ack & ~last;
                cnt_d   = cnt_q + CNT_W'(1);
                if (dmem.ack || last) begin
                    // Ack wins over a timeout landing in the same cycle.
                    state_d      = IDLE;
                    req_d        = 1'b0;
                    cnt_d        = '0;
                    wb_en_d      = dmem.ack & wb_en_in;
                    mem_to_reg_d = mem_r_en_in & ~mem_w_en_in;
                    alu_res_d    = alu_res_in;
                    dest_d       = dest_in;
                    mem_data_d   = (dmem.ack && !we_q) ? dmem.rdata : '0;
                    mem_err_d    = ~dmem.ack;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wb_en_q      <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_res_q    <= '0;
            mem_data_q   <= '0;
            dest_q       <= '0;
            align_err_q  <= 1'b0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wb_en_q      <= wb_en_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_res_q    <= alu_res_d;
            mem_data_q   <= mem_data_d;
            dest_q       <= dest_d;
            align_err_q  <= align_err_d;
            mem_err_q    <= mem_err_d;
        end
    end

    assign stall        = stall_c;
    assign pc_src       = branch_in & zero_in;
    assign dmem.req     = req_q;
    assign dmem.we      = we_q;
    assign dmem.addr    = addr_q;
    assign dmem.wdata   = wdata_q;
    assign wb_en_out    = wb_en_q;
    assign mem_to_reg   = mem_to_reg_q;
    assign alu_res_out  = alu_res_q;
    assign mem_data_out = mem_data_q;
    assign dest_out     = dest_q;
    assign align_err    = align_err_q;
    assign mem_err      = mem_err_q;
endmodule
